frogger_input_cond: RTL and testbench

FROGGER_INPUT_COND -- requirements
Module: frogger_input_cond

---
 rtl/frogger_input_cond.sv | 136 +++++++++++++
 tb/tb_frogger_input_cond.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frogger_input_cond.sv
// Frogger button front end: synchronises and debounces the four direction switches,
// then turns the held direction into single-cycle move strobes with auto-repeat.
module frogger_input_cond #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int REPEAT_DELAY   = 7500000,
    parameter int REPEAT_RATE    = 3750000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    input  logic i_Switch_3,
    input  logic i_Switch_4,
    input  logic i_Game_Active,
    input  logic i_Collided,
    output logic o_Up_Mvt,
    output logic o_Down_Mvt,
    output logic o_Left_Mvt,
    output logic o_Right_Mvt,
    output logic o_Any_Held
);

    localparam int DB_W    = $clog2(DEBOUNCE_LIMIT + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCKOUT} state_t;

    // Bit order: 0 = Up, 1 = Down, 2 = Left, 3 = Right (also the priority order).
    logic [3:0]      sw_raw;
    logic [3:0]      sync1, sync2, stable;
    logic [DB_W-1:0] db_cnt [4];

    state_t           state, state_n;
    logic [3:0]       latched, latched_n;
    logic [3:0]       strobe, strobe_n;
    logic [3:0]       pick;
    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_n;

    assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_LIMIT - 1)) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        pick = '0;
        if      (stable[0]) pick = 4'b0001;
        else if (stable[1]) pick = 4'b0010;
        else if (stable[2]) pick = 4'b0100;
        else if (stable[3]) pick = 4'b1000;
    end

    always_comb begin
        state_n   = state;
        latched_n = latched;
        rpt_cnt_n = rpt_cnt;
        strobe_n  = '0;
        case (state)
            IDLE: begin
                if (i_Game_Active && (stable != '0)) begin
                    strobe_n  = pick;
                    latched_n = pick;
                    rpt_cnt_n = RPT_W'(REPEAT_DELAY - 1);
                    state_n   = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if ((stable & latched) == '0) begin
                    state_n = IDLE;
                end else if (rpt_cnt == '0) begin
                    strobe_n  = latched;
                    rpt_cnt_n = RPT_W'(REPEAT_RATE - 1);
                    state_n   = REPEAT;
                end else begin
                    rpt_cnt_n = rpt_cnt - 1'b1;
                end
            end
            LOCKOUT: begin
                if ((stable == '0) && !i_Collided) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Game-off parks the FSM in IDLE but a pending lockout survives it;
        // a collision overrides everything else in the same cycle.
        if (!i_Game_Active) begin
            strobe_n = '0;
            if (state != LOCKOUT) state_n = IDLE;
        end
        if (i_Collided) begin
            strobe_n = '0;
            state_n  = LOCKOUT;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state   <= IDLE;
            latched <= '0;
            rpt_cnt <= '0;
            strobe  <= '0;
        end else begin
            state   <= state_n;
            latched <= latched_n;
            rpt_cnt <= rpt_cnt_n;
            strobe  <= strobe_n;
        end
    end

    assign o_Up_Mvt    = strobe[0];
    assign o_Down_Mvt  = strobe[1];
    assign o_Left_Mvt  = strobe[2];
    assign o_Right_Mvt = strobe[3];
    assign o_Any_Held  = |stable;

endmodule

// File: tb/tb_frogger_input_cond.sv
// Directed bench for frogger_input_cond: a cycle-level behavioural model checked every
// cycle, plus literal pulse-edge expectations for each scenario.
module tb_frogger_input_cond;

    localparam int DL = 4;
    localparam int RD = 8;
    localparam int RR = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic sw1, sw2, sw3, sw4, game, coll;
    logic up, down, left, right, any_held;

    frogger_input_cond #(
        .DEBOUNCE_LIMIT(DL),
        .REPEAT_DELAY  (RD),
        .REPEAT_RATE   (RR)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Switch_1   (sw1),
        .i_Switch_2   (sw2),
        .i_Switch_3   (sw3),
        .i_Switch_4   (sw4),
        .i_Game_Active(game),
        .i_Collided   (coll),
        .o_Up_Mvt     (up),
        .o_Down_Mvt   (down),
        .o_Left_Mvt   (left),
        .o_Right_Mvt  (right),
        .o_Any_Held   (any_held)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int held_cnt = 0;
    int plog[$];   // DUT pulses, encoded as cycle*4 + direction
    int expq[$];   // expected pulses for a window, encoded as edge*4 + direction

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 holding a direction, 2 locked out after a collision.
    // While holding, age counts cycles since the first pulse; repeats fall at
    // age == RD and every RR cycles after that.
    typedef struct packed {
        int mode;
        int dir;
        int age;
        int pulse;
    } fsm_t;

    logic [3:0] m_s1, m_s2, m_stab, m_strobe;
    int         m_run [4];
    int         m_mode, m_dir, m_age;
    fsm_t       m_nx;

    function automatic fsm_t fsm_next(input int mode, input int dir, input int age,
                                      input logic [3:0] stab, input logic g, input logic c);
        fsm_t r;
        r.mode = mode; r.dir = dir; r.age = age; r.pulse = -1;
        if (c) begin
            r.mode = 2;
        end else if (mode == 2) begin
            if (stab == 4'b0) r.mode = 0;
        end else if (!g) begin
            r.mode = 0;
        end else if (mode == 0) begin
            if (stab != 4'b0) begin
                for (int i = 3; i >= 0; i--) if (stab[i]) r.dir = i;
                r.pulse = r.dir;
                r.age   = 0;
                r.mode  = 1;
            end
        end else begin
            if (!stab[dir]) begin
                r.mode = 0;
            end else begin
                r.age = age + 1;
                if (r.age == RD || (r.age > RD && (r.age - RD) % RR == 0)) r.pulse = dir;
            end
        end
        return r;
    endfunction

    assign m_nx = fsm_next(m_mode, m_dir, m_age, m_stab, game, coll);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 4'b0; m_s2 <= 4'b0; m_stab <= 4'b0; m_strobe <= 4'b0;
            for (int i = 0; i < 4; i++) m_run[i] <= 0;
            m_mode <= 0; m_dir <= 0; m_age <= 0;
        end else begin
            m_s1 <= {sw4, sw3, sw2, sw1};
            m_s2 <= m_s1;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_stab[i]) begin
                    if (m_run[i] + 1 >= DL) begin
                        m_stab[i] <= m_s2[i];
                        m_run[i]  <= 0;
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                    end
                end else begin
                    m_run[i] <= 0;
                end
            end
            m_mode   <= m_nx.mode;
            m_dir    <= m_nx.dir;
            m_age    <= m_nx.age;
            m_strobe <= (m_nx.pulse >= 0) ? 4'(1 << m_nx.pulse) : 4'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("strobes", int'({right, left, down, up}), int'(m_strobe));
            chk("any_held", int'(any_held), int'(|m_stab));
            if (up)    plog.push_back(cyc * 4 + 0);
            if (down)  plog.push_back(cyc * 4 + 1);
            if (left)  plog.push_back(cyc * 4 + 2);
            if (right) plog.push_back(cyc * 4 + 3);
            if (any_held) held_cnt++;
        end
    end

    // ---------------- literal expectations ----------------
    task automatic expect_edge(input int e, input int dir);
        expq.push_back(e * 4 + dir);
    endtask

    task automatic check_pulses(input string nm, input int base, input int last);
        int got[$];
        foreach (plog[k])
            if (plog[k] / 4 > base && plog[k] / 4 <= last)
                got.push_back((plog[k] / 4 - base) * 4 + plog[k] % 4);
        chk({nm, "_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk({nm, "_edge*4+dir"}, got[i], expq[i]);
        expq.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    int base, base2, h0;

    initial begin
        rst_n = 1'b0;
        {sw1, sw2, sw3, sw4, coll} = '0;
        game = 1'b1;
        #1;
        chk("reset_strobes", int'({right, left, down, up}), 0);
        chk("reset_any_held", int'(any_held), 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);

        // Clean Up press: pulses at 7, 15, 19, 23, 27 within the first 30 edges.
        base = cyc; sw1 = 1'b1;
        wait_cyc(30);
        expect_edge(7, 0); expect_edge(15, 0); expect_edge(19, 0);
        expect_edge(23, 0); expect_edge(27, 0);
        check_pulses("up_hold", base, base + 30);
        sw1 = 1'b0;
        wait_cyc(14);

        // Left bouncing every 2 cycles never settles.
        base = cyc; h0 = held_cnt;
        for (int i = 0; i < 5; i++) begin
            sw3 = 1'b1; wait_cyc(2);
            sw3 = 1'b0; wait_cyc(2);
        end
        wait_cyc(10);
        check_pulses("bounce", base, base + 30);
        chk("bounce_held_cycles", held_cnt - h0, 0);

        // Down + Right together: Down wins; Right only after Down is released.
        base = cyc; sw2 = 1'b1; sw4 = 1'b1;
        wait_cyc(12);
        sw2 = 1'b0;
        wait_cyc(10);
        expect_edge(7, 1); expect_edge(15, 1); expect_edge(20, 3);
        check_pulses("down_right", base, base + 22);
        sw4 = 1'b0;
        wait_cyc(14);

        // Collision at edge 10 locks out until release; re-press resumes.
        base = cyc; sw1 = 1'b1;
        wait_cyc(9);
        coll = 1'b1;
        wait_cyc(1);
        coll = 1'b0;
        wait_cyc(10);
        expect_edge(7, 0);
        check_pulses("collide", base, base + 20);
        sw1 = 1'b0;
        wait_cyc(14);
        base2 = cyc; sw1 = 1'b1;
        wait_cyc(10);
        expect_edge(7, 0);
        check_pulses("repress", base2, base2 + 10);
        sw1 = 1'b0;
        wait_cyc(14);

        // Game inactive while Left held, then enabled.
        base = cyc; game = 1'b0; sw3 = 1'b1;
        wait_cyc(15);
        check_pulses("game_off", base, base + 15);
        game = 1'b1;
        wait_cyc(1);
        expect_edge(16, 2);
        check_pulses("game_on", base, base + 16);
        wait_cyc(4);
        sw3 = 1'b0;
        wait_cyc(14);

        // Reset across edge 12 during a held Up: re-debounce, next pulse at 19.
        base = cyc; sw1 = 1'b1;
        wait_cyc(11);
        rst_n = 1'b0;
        #1;
        chk("midreset_strobes", int'({right, left, down, up}), 0);
        chk("midreset_any_held", int'(any_held), 0);
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(10);
        expect_edge(7, 0); expect_edge(19, 0);
        check_pulses("midreset", base, base + 22);
        sw1 = 1'b0;
        wait_cyc(14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
